// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word, line bus, line address and victim buffer FSM states.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] pmem_bus;
  typedef logic [11:0]  lc3b_line_addr;

  // Victim buffer controller states
  typedef enum logic [1:0] {
    IDLE,
    RESP,
    READ,
    DRAIN
  } l2vb_state_t;

endpackage

// File: rtl/l2_victim_buffer_datapath.sv
// Victim buffer datapath: the single entry registers, hit compare, and the physical/L2
// address and data muxes. All mux outputs are zero unless explicitly selected.
module l2_victim_buffer_datapath
  import lc3b_types::*;
#(
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic     clk_i,
  input  logic     reset_i,
  input  lc3b_word l2_address_i,
  input  pmem_bus  l2_wdata_i,
  input  pmem_bus  phys_rdata_i,
  input  logic     capture_i,     // load entry from the L2 write
  input  logic     clear_i,       // entry has been written back
  input  logic     addr_read_i,   // phys address from the L2 request
  input  logic     addr_drain_i,  // phys address/data from the entry
  input  logic     rdata_buf_i,   // l2_rdata from the entry
  input  logic     rdata_phys_i,  // l2_rdata from memory
  output logic     hit_o,
  output logic     buf_valid_o,
  output lc3b_word phys_address_o,
  output pmem_bus  phys_wdata_o,
  output pmem_bus  l2_rdata_o
);

  localparam int unsigned LineW = 16 - OFFSET_BITS;

  logic [LineW-1:0] req_line;
  logic [LineW-1:0] buf_line_q;
  logic             buf_valid_q;
  pmem_bus          buf_data_q;
  logic             unused_offset;

  assign req_line      = l2_address_i[15:OFFSET_BITS];
  assign unused_offset = ^l2_address_i[OFFSET_BITS-1:0];

  // Entry registers; reset discards any buffered line
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_valid_q <= 1'b0;
      buf_line_q  <= '0;
      buf_data_q  <= '0;
    end else if (capture_i) begin
      buf_valid_q <= 1'b1;
      buf_line_q  <= req_line;
      buf_data_q  <= l2_wdata_i;
    end else if (clear_i) begin
      buf_valid_q <= 1'b0;
    end
  end

  assign hit_o       = buf_valid_q && (req_line == buf_line_q);
  assign buf_valid_o = buf_valid_q;

  // Output muxes, gated to zero when not selected
  always_comb begin
    phys_address_o = '0;
    phys_wdata_o   = '0;
    l2_rdata_o     = '0;
    if (addr_read_i) begin
      phys_address_o = {req_line, {OFFSET_BITS{1'b0}}};
    end else if (addr_drain_i) begin
      phys_address_o = {buf_line_q, {OFFSET_BITS{1'b0}}};
      phys_wdata_o   = buf_data_q;
    end
    if (rdata_phys_i) begin
      l2_rdata_o = phys_rdata_i;
    end else if (rdata_buf_i) begin
      l2_rdata_o = buf_data_q;
    end
  end

endmodule

// File: rtl/l2_victim_buffer.sv
// Single-entry victim buffer between the L2 cache and physical memory. Dirty evictions are
// parked in the entry and written back when the L2 side is quiet; reads that hit the entry
// are served from it without touching memory.
module l2_victim_buffer
  import lc3b_types::*;
#(
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  lc3b_word l2_address,
  input  logic     l2_read,
  input  logic     l2_write,
  input  pmem_bus  l2_wdata,
  output pmem_bus  l2_rdata,
  output logic     l2_resp,
  output lc3b_word phys_address,
  output logic     phys_read,
  output logic     phys_write,
  output pmem_bus  phys_wdata,
  input  pmem_bus  phys_rdata,
  input  logic     phys_resp
);

  l2vb_state_t state_q, state_d;

  logic hit;
  logic buf_valid;
  logic capture;
  logic clear;
  logic addr_read;
  logic addr_drain;
  logic rdata_buf;
  logic rdata_phys;

  l2_victim_buffer_datapath #(
    .OFFSET_BITS(OFFSET_BITS)
  ) u_dp (
    .clk_i         (clk),
    .reset_i       (reset),
    .l2_address_i  (l2_address),
    .l2_wdata_i    (l2_wdata),
    .phys_rdata_i  (phys_rdata),
    .capture_i     (capture),
    .clear_i       (clear),
    .addr_read_i   (addr_read),
    .addr_drain_i  (addr_drain),
    .rdata_buf_i   (rdata_buf),
    .rdata_phys_i  (rdata_phys),
    .hit_o         (hit),
    .buf_valid_o   (buf_valid),
    .phys_address_o(phys_address),
    .phys_wdata_o  (phys_wdata),
    .l2_rdata_o    (l2_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs; a read wins over a simultaneous write
  always_comb begin
    state_d    = state_q;
    l2_resp    = 1'b0;
    phys_read  = 1'b0;
    phys_write = 1'b0;
    capture    = 1'b0;
    clear      = 1'b0;
    addr_read  = 1'b0;
    addr_drain = 1'b0;
    rdata_buf  = 1'b0;
    rdata_phys = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (l2_read) begin
          state_d = hit ? RESP : READ;
        end else if (l2_write) begin
          if (!buf_valid || hit) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            // Entry busy with another line: write it back, accept the write afterwards
            state_d = DRAIN;
          end
        end else if (buf_valid) begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        l2_resp   = 1'b1;
        rdata_buf = 1'b1;
        state_d   = IDLE;
      end
      READ: begin
        phys_read = 1'b1;
        addr_read = 1'b1;
        if (phys_resp) begin
          l2_resp    = 1'b1;
          rdata_phys = 1'b1;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        phys_write = 1'b1;
        addr_drain = 1'b1;
        if (phys_resp) begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
